// File: rtl/step_timer_if.sv
// Host-side bundle for step_timer: run control, run parameters and timer status.
interface step_timer_if #(
  parameter int WIDTH   = 16,
  parameter int PULSE_W = 8
);
  logic               start;
  logic               abort;
  logic               hold;
  logic [WIDTH-1:0]   period;
  logic [PULSE_W-1:0] num_pulses;
  logic               busy;
  logic               step;
  logic               done;
  logic [WIDTH-1:0]   count;
  logic [PULSE_W-1:0] remaining;

  modport master (
    output start, abort, hold, period, num_pulses,
    input  busy, step, done, count, remaining
  );

  modport slave (
    input  start, abort, hold, period, num_pulses,
    output busy, step, done, count, remaining
  );
endinterface

// File: rtl/step_timer.sv
// Programmable down-counting step-pulse timer with done strobe.
// Optional continuous mode (num_pulses==0) enabled by macro STEP_TIMER_CONTINUOUS_EN.
module step_timer #(
  parameter int WIDTH   = 16,
  parameter int PULSE_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  step_timer_if.slave tif
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   per, per_n;
  logic [PULSE_W-1:0] rem, rem_n;
  logic               step_r, step_n;
  logic               done_r, done_n;
  logic               cont, cont_n;
  logic               reject;
  logic               cont_req;

`ifdef STEP_TIMER_CONTINUOUS_EN
  assign reject   = (tif.period == '0);
  assign cont_req = (tif.num_pulses == '0);
`else
  assign reject   = (tif.period == '0) || (tif.num_pulses == '0);
  assign cont_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      per    <= '0;
      rem    <= '0;
      step_r <= 1'b0;
      done_r <= 1'b0;
      cont   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      per    <= per_n;
      rem    <= rem_n;
      step_r <= step_n;
      done_r <= done_n;
      cont   <= cont_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per;
    rem_n   = rem;
    cont_n  = cont;
    step_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tif.start && !tif.abort) begin
          if (reject) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            cnt_n   = tif.period - 1'b1;
            per_n   = tif.period;
            rem_n   = cont_req ? '0 : tif.num_pulses;
            cont_n  = cont_req;
          end
        end
      end
      RUN, HOLD: begin
        if (tif.abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          rem_n   = '0;
          cont_n  = 1'b0;
        end else if (tif.hold) begin
          state_n = HOLD;
        end else begin
          // Leaving HOLD also counts on that edge, so pause cycles add exactly to spacing.
          state_n = RUN;
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            step_n = 1'b1;
            cnt_n  = per - 1'b1;
            if (!cont) begin
              rem_n = rem - 1'b1;
              if (rem == PULSE_W'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
                cnt_n   = '0;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tif.busy      = (state != IDLE);
  assign tif.step      = step_r;
  assign tif.done      = done_r;
  assign tif.count     = cnt;
  assign tif.remaining = rem;

endmodule

// File: tb/tb_step_timer.sv
// Self-checking bench for step_timer: directed scenarios plus randomized run against a pulse-timing model.
module tb_step_timer;
  localparam int W  = 16;
  localparam int PW = 8;
`ifdef STEP_TIMER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  step_timer_if #(.WIDTH(W), .PULSE_W(PW)) tif ();
  step_timer #(.WIDTH(W), .PULSE_W(PW)) dut (.clk(clk), .rst(rst), .tif(tif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a run is described by how many un-held edges have elapsed since the start edge.
  logic          m_busy, m_step, m_done;
  logic [W-1:0]  m_count;
  logic [PW-1:0] m_rem;
  int            m_p, m_n, m_act;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_step <= 1'b0; m_done <= 1'b0;
      m_count <= '0; m_rem <= '0; m_p <= 1; m_n <= 0; m_act <= 0;
    end else begin
      m_step <= 1'b0;
      m_done <= 1'b0;
      if (!m_busy) begin
        if (tif.start && !tif.abort) begin
          if (tif.period == 0 || (tif.num_pulses == 0 && !CONT)) begin
            m_done <= 1'b1;
          end else begin
            m_busy  <= 1'b1;
            m_p     <= int'(tif.period);
            m_n     <= int'(tif.num_pulses);
            m_act   <= 0;
            m_count <= tif.period - 1;
            m_rem   <= tif.num_pulses;
          end
        end
      end else if (tif.abort) begin
        m_busy <= 1'b0; m_count <= '0; m_rem <= '0;
      end else if (!tif.hold) begin
        m_act  <= m_act + 1;
        m_step <= ((m_act + 1) % m_p) == 0;
        if (m_n != 0 && (m_act + 1) / m_p == m_n) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_count <= '0; m_rem <= '0;
        end else begin
          m_count <= W'(m_p - 1 - ((m_act + 1) % m_p));
          m_rem   <= (m_n == 0) ? '0 : PW'(m_n - (m_act + 1) / m_p);
        end
      end
    end
  end

  task automatic kick(input int p, input int n);
    @(negedge clk);
    tif.period = W'(p); tif.num_pulses = PW'(n); tif.start = 1'b1;
    @(negedge clk);
    tif.start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tif.start = 0; tif.abort = 0; tif.hold = 0; tif.period = '0; tif.num_pulses = '0;
    #1;
    checks++;
    if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== '0) begin
      failures++; $display("FAIL reset_init got b%0b s%0b d%0b c%0d r%0d want all 0",
                           tif.busy, tif.step, tif.done, tif.count, tif.remaining);
    end
    settle(2); rst = 1'b1;
    kick(5, 3);
    settle(6);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== '0) begin
      failures++; $display("FAIL reset_midrun got b%0b s%0b d%0b c%0d r%0d want all 0",
                           tif.busy, tif.step, tif.done, tif.count, tif.remaining);
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (tif.done !== 1'b0 || tif.busy !== 1'b0) begin
        failures++; $display("FAIL reset_release k=%0d got d%0b b%0b want d0 b0", k, tif.done, tif.busy);
      end
    end
  endtask

  task automatic test_basic();
    kick(4, 3);
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.step !== (k == 4 || k == 8 || k == 12) || tif.done !== (k == 12) || tif.busy !== (k < 12)) begin
        failures++; $display("FAIL basic k=%0d got s%0b d%0b b%0b want s%0b d%0b b%0b", k, tif.step, tif.done,
                             tif.busy, (k == 4 || k == 8 || k == 12), (k == 12), (k < 12));
      end
      checks++;
      if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== {m_busy, m_step, m_done, m_count, m_rem}) begin
        failures++; $display("FAIL basic_model k=%0d got c%0d r%0d want c%0d r%0d", k, tif.count, tif.remaining, m_count, m_rem);
      end
    end
  endtask

  task automatic test_period1();
    kick(1, 5);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.step !== (k >= 1 && k <= 5) || tif.done !== (k == 5) || tif.remaining !== PW'(k <= 5 ? 5 - k : 0)) begin
        failures++; $display("FAIL period1 k=%0d got s%0b d%0b r%0d want s%0b d%0b r%0d", k, tif.step, tif.done,
                             tif.remaining, (k >= 1 && k <= 5), (k == 5), (k <= 5 ? 5 - k : 0));
      end
    end
  endtask

  task automatic test_hold();
    kick(6, 2);
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.step !== (k == 9 || k == 15) || tif.done !== (k == 15)) begin
        failures++; $display("FAIL hold k=%0d got s%0b d%0b want s%0b d%0b", k, tif.step, tif.done, (k == 9 || k == 15), (k == 15));
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (tif.count !== W'(3)) begin
          failures++; $display("FAIL hold_freeze k=%0d got c%0d want c3", k, tif.count);
        end
      end
      checks++;
      if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== {m_busy, m_step, m_done, m_count, m_rem}) begin
        failures++; $display("FAIL hold_model k=%0d got c%0d r%0d want c%0d r%0d", k, tif.count, tif.remaining, m_count, m_rem);
      end
      if (k == 2) tif.hold = 1'b1;
      if (k == 5) tif.hold = 1'b0;
    end
  endtask

  task automatic test_abort();
    kick(10, 2);
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 3) begin
        checks++;
        if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== '0) begin
          failures++; $display("FAIL abort k=%0d got b%0b s%0b d%0b c%0d r%0d want all 0", k, tif.busy, tif.step,
                               tif.done, tif.count, tif.remaining);
        end
      end
      if (k == 2) tif.abort = 1'b1;
      if (k == 3) tif.abort = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    kick(3, 2);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.step !== (k == 3 || k == 6) || tif.done !== (k == 6) || tif.busy !== (k < 6)) begin
        failures++; $display("FAIL busy_start k=%0d got s%0b d%0b b%0b want s%0b d%0b b%0b", k, tif.step, tif.done,
                             tif.busy, (k == 3 || k == 6), (k == 6), (k < 6));
      end
      if (k == 1) begin tif.start = 1'b1; tif.period = W'(7); tif.num_pulses = PW'(9); end
      if (k == 2) tif.start = 1'b0;
    end
  endtask

  task automatic test_zero();
    kick(0, 3);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.done !== (k == 0) || tif.busy !== 1'b0 || tif.step !== 1'b0) begin
        failures++; $display("FAIL zero_period k=%0d got d%0b b%0b s%0b want d%0b b0 s0", k, tif.done, tif.busy, tif.step, (k == 0));
      end
    end
`ifdef STEP_TIMER_CONTINUOUS_EN
    kick(2, 0);
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.step !== (k > 0 && k % 2 == 0) || tif.done !== 1'b0 || tif.busy !== 1'b1 || tif.remaining !== '0) begin
        failures++; $display("FAIL continuous k=%0d got s%0b d%0b b%0b r%0d want s%0b d0 b1 r0", k, tif.step, tif.done,
                             tif.busy, tif.remaining, (k > 0 && k % 2 == 0));
      end
    end
    tif.abort = 1'b1;
    @(negedge clk);
    tif.abort = 1'b0;
    checks++;
    if (tif.busy !== 1'b0 || tif.done !== 1'b0) begin
      failures++; $display("FAIL continuous_abort got b%0b d%0b want b0 d0", tif.busy, tif.done);
    end
`else
    kick(5, 0);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tif.done !== (k == 0) || tif.busy !== 1'b0 || tif.step !== 1'b0) begin
        failures++; $display("FAIL zero_pulses k=%0d got d%0b b%0b s%0b want d%0b b0 s0", k, tif.done, tif.busy, tif.step, (k == 0));
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if ({tif.busy, tif.step, tif.done, tif.count, tif.remaining} !== {m_busy, m_step, m_done, m_count, m_rem}) begin
        failures++; $display("FAIL random i=%0d got b%0b s%0b d%0b c%0d r%0d want b%0b s%0b d%0b c%0d r%0d", i,
                             tif.busy, tif.step, tif.done, tif.count, tif.remaining, m_busy, m_step, m_done, m_count, m_rem);
      end
      tif.start      = ($urandom_range(0, 7) == 0);
      tif.abort      = ($urandom_range(0, 59) == 0);
      tif.hold       = ($urandom_range(0, 5) == 0);
      tif.period     = W'($urandom_range(0, 6));
      tif.num_pulses = PW'($urandom_range(0, 4));
    end
    tif.start = 0; tif.abort = 0; tif.hold = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    settle(2);
    test_basic();
    settle(2);
    test_period1();
    settle(2);
    test_hold();
    settle(2);
    test_abort();
    settle(2);
    test_back_to_back();
    settle(2);
    test_zero();
    settle(2);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
